// File: rtl/aes_key_pkg.sv
// Shared constants, key-length encodings and FSM states for the key word loader.
package aes_key_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_RSVD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

  // Number of key words for a key_len code; the reserved code behaves as 128b.
  function automatic logic [CNT_W-1:0] nwords(input logic [1:0] kl);
    logic [CNT_W-1:0] n;
    case (key_len_e'(kl))
      KL_192:  n = CNT_W'(6);
      KL_256:  n = CNT_W'(8);
      default: n = CNT_W'(4);
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_slot_demux.sv
// Counter-indexed write demux: index + write enable -> one-hot slot enables.
module key_slot_demux
  import aes_key_pkg::*;
(
  input  logic [IDX_W-1:0]     idx,
  input  logic                 we,
  output logic [NUM_SLOTS-1:0] slot_en_c
);

  always_comb begin
    slot_en_c = '0;
    if (we) slot_en_c = NUM_SLOTS'(1) << idx;
  end

endmodule

// File: rtl/key_word_loader.sv
// Loads a cipher key word-by-word into 8 slot registers and fans them out in parallel.
// Build option KEY_LOADER_BYTESWAP_EN: byte-reverse each incoming word before storage.
module key_word_loader
  import aes_key_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        key_len,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [WORD_W-1:0] slot_0,
  output logic [WORD_W-1:0] slot_1,
  output logic [WORD_W-1:0] slot_2,
  output logic [WORD_W-1:0] slot_3,
  output logic [WORD_W-1:0] slot_4,
  output logic [WORD_W-1:0] slot_5,
  output logic [WORD_W-1:0] slot_6,
  output logic [WORD_W-1:0] slot_7
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     word_cnt_q;
  logic [CNT_W-1:0]     nwords_q;
  logic                 accept_c;
  logic [NUM_SLOTS-1:0] slot_en_c;
  logic [WORD_W-1:0]    store_word;
  logic [WORD_W-1:0]    slots_q [NUM_SLOTS];

`ifdef KEY_LOADER_BYTESWAP_EN
  assign store_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
  assign store_word = in_word;
`endif

  // Next-state logic; start restarts the load from any state and beats a same-cycle word.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (start) begin
          state_d = ST_LOAD;
        end else if (in_valid) begin
          accept_c = 1'b1;
          if (word_cnt_q == nwords_q - CNT_W'(1)) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = start ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Control outputs track the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      nwords_q  <= CNT_W'(4);
      word_cnt_q <= '0;
    end else begin
      in_ready <= (state_d == ST_LOAD);
      busy     <= (state_d == ST_LOAD);
      done     <= (state_d == ST_FIN);
      if (start) begin
        key_valid  <= 1'b0;
        nwords_q   <= nwords(key_len);
        word_cnt_q <= '0;
      end else begin
        if (state_q == ST_FIN) key_valid <= 1'b1;
        if (accept_c)          word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
    end
  end

  key_slot_demux u_demux (
    .idx       (word_cnt_q[IDX_W-1:0]),
    .we        (accept_c),
    .slot_en_c (slot_en_c)
  );

  // Slot registers: cleared on start, written one-hot otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      for (int k = 0; k < NUM_SLOTS; k++) slots_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (slot_en_c[k]) slots_q[k] <= store_word;
      end
    end
  end

  assign word_cnt = word_cnt_q;
  assign slot_0   = slots_q[0];
  assign slot_1   = slots_q[1];
  assign slot_2   = slots_q[2];
  assign slot_3   = slots_q[3];
  assign slot_4   = slots_q[4];
  assign slot_5   = slots_q[5];
  assign slot_6   = slots_q[6];
  assign slot_7   = slots_q[7];

endmodule

// File: tb/tb_key_word_loader.sv
// Scoreboard bench for key_word_loader: loads push expected keys, a monitor checks on done.
module tb_key_word_loader;
  import aes_key_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid;
  logic [1:0]        key_len;
  logic [WORD_W-1:0] in_word;
  logic              in_ready, busy, done, key_valid;
  logic [3:0]        word_cnt;
  logic [WORD_W-1:0] slot_0, slot_1, slot_2, slot_3, slot_4, slot_5, slot_6, slot_7;

  always #5 clk = ~clk;

  key_word_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len),
    .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready), .busy(busy),
    .done(done), .key_valid(key_valid), .word_cnt(word_cnt),
    .slot_0(slot_0), .slot_1(slot_1), .slot_2(slot_2), .slot_3(slot_3),
    .slot_4(slot_4), .slot_5(slot_5), .slot_6(slot_6), .slot_7(slot_7)
  );

  typedef struct packed {
    logic [7:0][31:0] s;
    logic [3:0]       cnt;
  } exp_t;

  exp_t             sbq[$];
  exp_t             e_mon;
  logic [31:0]      words [8];
  logic [7:0][31:0] act_slots;
  int               errors = 0;
  int               checks = 0;
  int               dones = 0;
  int               exp_dones = 0;
  logic             done_prev = 1'b0;

  assign act_slots = {slot_7, slot_6, slot_5, slot_4, slot_3, slot_2, slot_1, slot_0};

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef KEY_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) e.s[i] = stored(words[i]);
    e.cnt = 4'(n);
    sbq.push_back(e);
    exp_dones++;
  endtask

  task automatic do_start(input logic [1:0] kl);
    start   = 1'b1;
    key_len = kl;
    @(negedge clk);
    start   = 1'b0;
    key_len = ~kl;
  endtask

  task automatic send(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_word  = words[i];
      chk("in_ready_word", 32'(in_ready), 32'd1);
      @(negedge clk);
      if (gaps && i < n - 1) begin
        in_valid = 1'b0;
        in_word  = 32'hFFFF_FFFF;
        chk("in_ready_gap", 32'(in_ready), 32'd1);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest expected key.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      dones++;
      if (done_prev) begin
        checks++;
        errors++;
        $display("FAIL done_width: got 2+ cycles expected 1");
      end
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e_mon = sbq.pop_front();
        for (int k = 0; k < 8; k++) chk($sformatf("slot_%0d", k), act_slots[k], e_mon.s[k]);
        chk("word_cnt_at_done", 32'(word_cnt), 32'(e_mon.cnt));
      end
    end
    done_prev <= (done === 1'b1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; key_len = 2'b10; in_word = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    // T1: reset dominates start and in_valid
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("rst_slot_0", slot_0, 32'd0);
    chk("rst_slot_7", slot_7, 32'd0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    // T2: 128-bit back-to-back
    words = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C, 0, 0, 0, 0};
    push_exp(4);
    do_start(2'b00);
    chk("t2_busy", 32'(busy), 32'd1);
    send(4, 1'b0);
    @(negedge clk);
    chk("t2_key_valid", 32'(key_valid), 32'd1);
    chk("t2_word_cnt", 32'(word_cnt), 32'd4);
    chk("t2_busy_idle", 32'(busy), 32'd0);
    chk("t2_in_ready_idle", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_word = 32'h1234_5678;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_slot_0", slot_0, stored(32'h2B7E1516));
    chk("idle_slot_4", slot_4, 32'd0);
    chk("idle_word_cnt", 32'(word_cnt), 32'd4);

    // T3: 256-bit with gaps
    words = '{32'h603DEB10, 32'h15CA71BE, 32'h2B73AEF0, 32'h857D7781,
              32'h1F352C07, 32'h3B6108D7, 32'h2D9810A3, 32'h0914DFF4};
    push_exp(8);
    do_start(2'b10);
    chk("t3_key_valid_cleared", 32'(key_valid), 32'd0);
    send(8, 1'b1);
    @(negedge clk);
    chk("t3_key_valid", 32'(key_valid), 32'd1);

    // T4: abort a 192-bit load; the word presented with start is dropped
    words = '{32'h8E73B0F7, 32'hDA0E6452, 32'hC810F32B, 0, 0, 0, 0, 0};
    do_start(2'b01);
    send(3, 1'b0);
    chk("t4_mid_cnt", 32'(word_cnt), 32'd3);
    start = 1'b1; key_len = 2'b00; in_valid = 1'b1; in_word = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("t4_abort_cnt", 32'(word_cnt), 32'd0);
    chk("t4_abort_slot_0", slot_0, 32'd0);
    chk("t4_abort_slot_2", slot_2, 32'd0);
    chk("t4_abort_slot_7", slot_7, 32'd0);
    chk("t4_abort_done", 32'(done), 32'd0);
    chk("t4_abort_in_ready", 32'(in_ready), 32'd1);
    words = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 0, 0, 0, 0};
    push_exp(4);
    send(4, 1'b0);
    @(negedge clk);
    chk("t4_key_valid", 32'(key_valid), 32'd1);

    // T5/T6: reserved key_len acts as 128b; byte order of the stored word
    words = '{32'h01020304, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 0, 0, 0, 0};
    push_exp(4);
    do_start(2'b11);
    send(4, 1'b0);
    @(negedge clk);
    chk("t5_key_valid", 32'(key_valid), 32'd1);
    chk("t5_word_cnt", 32'(word_cnt), 32'd4);
`ifdef KEY_LOADER_BYTESWAP_EN
    chk("t6_slot_0_order", slot_0, 32'h04030201);
`else
    chk("t6_slot_0_order", slot_0, 32'h01020304);
`endif

    // Reset mid-load
    do_start(2'b10);
    send(2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_slot_0", slot_0, 32'd0);
    chk("midrst_key_valid", 32'(key_valid), 32'd0);

    repeat (3) @(negedge clk);
    chk("pending_expected", 32'(sbq.size()), 32'd0);
    chk("done_count", 32'(dones), 32'(exp_dones));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
